mem_stage: RTL and testbench

Memory-access stage sitting directly downstream of the EX/MEM pipeline register, feeding the register-file write-back path. It consumes the EX/MEM control and data fields and performs the word load or store against an external data memory over a variable-latency req/ack handshake. While an access is outstanding it freezes upstream stages and inserts bubbles downstream. It owns the MEM/WB pipeline register and reports misaligned-access and memory-timeout errors.

---
 rtl/mem_stage.sv | 129 ++++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory req/ack access, stall control, MEM/WB register
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_data_i,
  input  logic [4:0]  RdAddr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [1:0]  WB_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  RdAddr_o,
  output logic [1:0]  err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_buf;
  logic          r_kill;

  logic w_mem_op;
  logic w_aligned;
  logic w_start;

  assign w_mem_op  = MemRead_i | MemWrite_i;
  assign w_aligned = (Address_i[1:0] == 2'b00);
  assign w_start   = (r_state == S_IDLE) & w_mem_op & w_aligned;

  // Stall starts combinationally on an aligned access so upstream freezes in the arrival cycle;
  // forced low while reset is asserted so an aborted access releases the pipeline at once.
  assign stall_o = rst_i & (w_start | (r_state == S_REQ));

  // Access FSM: issue request, wait for ack or timeout, latch result, track sticky errors
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_buf        <= 32'd0;
      r_kill       <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'd0;
      dmem_wdata_o <= 32'd0;
      err_o        <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= MemWrite_i;
            dmem_addr_o  <= Address_i;
            dmem_wdata_o <= Write_data_i;
            r_cnt        <= '0;
            r_state      <= S_REQ;
          end else if (w_mem_op) begin
            err_o[0] <= 1'b1;
          end
        end
        S_REQ: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            r_buf      <= dmem_we_o ? 32'd0 : dmem_rdata_i;
            r_state    <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            dmem_req_o <= 1'b0;
            r_buf      <= 32'd0;
            r_kill     <= 1'b1;
            err_o[1]   <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_kill  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, result on DONE, direct pass-through otherwise
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      WB_o        <= 2'b00;
      ReadData_o  <= 32'd0;
      ALUResult_o <= 32'd0;
      RdAddr_o    <= 5'd0;
    end else if (stall_o) begin
      WB_o <= 2'b00;
    end else if (r_state == S_DONE) begin
      WB_o        <= {WB_i[1], WB_i[0] & ~r_kill};
      ReadData_o  <= r_buf;
      ALUResult_o <= Address_i;
      RdAddr_o    <= RdAddr_i;
    end else if (w_mem_op) begin
      // Only reachable for a misaligned access: retire it harmlessly
      WB_o        <= 2'b00;
      ReadData_o  <= 32'd0;
      ALUResult_o <= Address_i;
      RdAddr_o    <= RdAddr_i;
    end else begin
      WB_o        <= WB_i;
      ReadData_o  <= 32'd0;
      ALUResult_o <= Address_i;
      RdAddr_o    <= RdAddr_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_in;
  logic        mem_rd, mem_wr;
  logic [31:0] addr_in, wdata_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic        resp_ack, late_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [1:0]  wb_out;
  logic [31:0] rdata_out, alu_out;
  logic [4:0]  rd_out;
  logic [1:0]  err;

  always #5 clk = ~clk;

  assign dmem_ack = resp_ack | late_ack;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .WB_i        (wb_in),
    .MemRead_i   (mem_rd),
    .MemWrite_i  (mem_wr),
    .Address_i   (addr_in),
    .Write_data_i(wdata_in),
    .RdAddr_i    (rd_in),
    .dmem_req_o  (dmem_req),
    .dmem_we_o   (dmem_we),
    .dmem_addr_o (dmem_addr),
    .dmem_wdata_o(dmem_wdata),
    .dmem_ack_i  (dmem_ack),
    .dmem_rdata_i(dmem_rdata),
    .stall_o     (stall),
    .WB_o        (wb_out),
    .ReadData_o  (rdata_out),
    .ALUResult_o (alu_out),
    .RdAddr_o    (rd_out),
    .err_o       (err)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rdat;
    logic [31:0] alu;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic        tb_valid = 1'b0;
  logic        pend = 1'b0;
  int          ack_k = 0;
  logic [31:0] resp_rdata = 32'd0;
  int          n_req = 0;
  int          req_cycles = 0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_addr = 32'd0;
  logic [31:0] cur_wdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: acks in the ack_k-th request cycle (0 = never), checks request fields stay stable
  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      n_req++;
      req_cycles++;
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, cur_we});
      chk("dmem_addr", dmem_addr, cur_addr);
      if (cur_we) chk("dmem_wdata", dmem_wdata, cur_wdata);
      resp_ack   = (ack_k != 0) && (n_req == ack_k);
      dmem_rdata = resp_rdata;
    end else begin
      n_req    = 0;
      resp_ack = 1'b0;
    end
  end

  // Monitor: one MEM/WB result appears after every edge that accepted a bench instruction
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard unexpected output wb=%h", wb_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_o", {30'd0, wb_out}, {30'd0, e.wb});
          chk("readdata", rdata_out, e.rdat);
          chk("aluresult", alu_out, e.alu);
          chk("rdaddr", {27'd0, rd_out}, {27'd0, e.rd});
        end
      end
      pend = tb_valid && (stall === 1'b0);
    end
  end

  task automatic drive_nop();
    tb_valid = 1'b0;
    wb_in    = 2'b00;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_in  = 32'd0;
    wdata_in = 32'd0;
    rd_in    = 5'd0;
  endtask

  task automatic issue(input string name, input logic [1:0] wb, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] d,
                       input int k, input logic [31:0] rdat,
                       input logic [1:0] ewb, input logic [31:0] erd,
                       input int estall, input int ereq);
    exp_t e;
    int   st;
    int   r0;
    logic acc;
    e.wb = ewb; e.rdat = erd; e.alu = a; e.rd = d;
    exp_q.push_back(e);
    wb_in = wb; mem_rd = r; mem_wr = w; addr_in = a; wdata_in = wd; rd_in = d;
    ack_k = k; resp_rdata = rdat; cur_we = w; cur_addr = a; cur_wdata = wd;
    tb_valid = 1'b1;
    st = 0;
    r0 = req_cycles;
    acc = 1'b0;
    for (int cyc = 0; cyc < 40 && !acc; cyc++) begin
      @(negedge clk);
      acc = (stall === 1'b0);
      if (!acc) begin
        st++;
        if (st >= 2) chk($sformatf("%s bubble", name), {30'd0, wb_out}, 32'd0);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s accept actual=stalled required=accepted", name);
    end
    chk($sformatf("%s stall_cycles", name), st, estall);
    chk($sformatf("%s req_cycles", name), req_cycles - r0, ereq);
    drive_nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    late_ack = 1'b0;
    resp_ack = 1'b0;
    dmem_rdata = 32'd0;
    drive_nop();
    repeat (3) @(posedge clk);
    #1;
    chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst wb_o", {30'd0, wb_out}, 32'd0);
    chk("rst readdata", rdata_out, 32'd0);
    chk("rst aluresult", alu_out, 32'd0);
    chk("rst rdaddr", {27'd0, rd_out}, 32'd0);
    chk("rst err", {30'd0, err}, 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue("alu", 2'b01, 0, 0, 32'h10, 32'h0, 5'd5, 1, 32'h0, 2'b01, 32'h0, 0, 0);
    issue("load1", 2'b11, 1, 0, 32'h100, 32'h0, 5'd7, 1, 32'hDEADBEEF, 2'b11, 32'hDEADBEEF, 2, 1);
    chk("err after load1", {30'd0, err}, 32'd0);
    issue("store5", 2'b00, 0, 1, 32'h204, 32'h12345678, 5'd0, 5, 32'hFFFFFFFF, 2'b00, 32'h0, 6, 5);
    issue("rdwr_both", 2'b00, 1, 1, 32'h600, 32'h0000A5A5, 5'd0, 1, 32'hFFFFFFFF, 2'b00, 32'h0, 2, 1);
    issue("misaligned", 2'b11, 1, 0, 32'h102, 32'h0, 5'd3, 1, 32'h0, 2'b00, 32'h0, 0, 0);
    chk("err misaligned", {30'd0, err}, 32'd1);
    issue("ack_at_16", 2'b11, 1, 0, 32'h304, 32'h0, 5'd8, 16, 32'hCAFEF00D, 2'b11, 32'hCAFEF00D, 17, 16);
    chk("err ack_at_16", {30'd0, err}, 32'd1);
    issue("timeout", 2'b11, 1, 0, 32'h300, 32'h0, 5'd9, 0, 32'h55555555, 2'b10, 32'h0, 17, 16);
    chk("err timeout", {30'd0, err}, 32'd3);
    issue("b2b_a", 2'b11, 1, 0, 32'h500, 32'h0, 5'd10, 1, 32'h11111111, 2'b11, 32'h11111111, 2, 1);
    issue("b2b_b", 2'b11, 1, 0, 32'h504, 32'h0, 5'd11, 2, 32'h22222222, 2'b11, 32'h22222222, 3, 2);
    issue("alu2", 2'b01, 0, 0, 32'h20, 32'h0, 5'd6, 1, 32'h0, 2'b01, 32'h0, 0, 0);
    chk("err sticky", {30'd0, err}, 32'd3);

    // Reset in the third request cycle of a load that would never be acked
    wb_in = 2'b11; mem_rd = 1'b1; addr_in = 32'h400; rd_in = 5'd4;
    ack_k = 0; cur_we = 1'b0; cur_addr = 32'h400; cur_wdata = 32'h0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre-reset dmem_req", {31'd0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("midreset stall", {31'd0, stall}, 32'd0);
    chk("midreset err", {30'd0, err}, 32'd0);
    chk("midreset wb_o", {30'd0, wb_out}, 32'd0);
    drive_nop();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dmem_rdata = 32'hBADBAD00;
    late_ack = 1'b1;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    chk("late ack dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("late ack stall", {31'd0, stall}, 32'd0);
    issue("alu_after_rst", 2'b01, 0, 0, 32'h44, 32'h0, 5'd12, 1, 32'h0, 2'b01, 32'h0, 0, 0);
    chk("err after rst", {30'd0, err}, 32'd0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
